// File: rtl/buyruk_obek_getirici_pkg.sv
// Shared definitions for the instruction-cache line fetcher.
// Holds the FSM state encoding, word/line geometry and default sizing,
// plus a helper that aligns an address down to the start of its line.
package buyruk_obek_getirici_pkg;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        ISTEK  = 2'd1,
        VERI   = 2'd2,
        TESLIM = 2'd3
    } durum_t;

    localparam int KELIME_W                 = 32;
    localparam int SATIR_OFSET_W            = 4;
    localparam int VARSAYILAN_KELIME_SAYISI = 4;
    localparam int VARSAYILAN_ZAMAN_ASIMI   = 255;

    function automatic logic [31:0] satir_hizala(input logic [31:0] adres);
        return {adres[31:SATIR_OFSET_W], {SATIR_OFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/buyruk_obek_getirici_obek_birlestirici.sv
// Block assembler: a bank of KELIME_SAYISI 32-bit registers. When yaz is
// high the word kelime lands in slot indeks; other slots keep their value.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears the block)
//   yaz       - write enable
//   indeks    - slot to write
//   kelime    - 32-bit word to store
//   obek      - assembled block, slot i at bits [32*i +: 32]
module obek_birlestirici
    import buyruk_obek_getirici_pkg::*;
#(
    parameter int  KELIME_SAYISI = VARSAYILAN_KELIME_SAYISI,
    localparam int INDEKS_W      = (KELIME_SAYISI > 1) ? $clog2(KELIME_SAYISI) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                yaz,
    input  logic [INDEKS_W-1:0]                 indeks,
    input  logic [KELIME_W-1:0]                 kelime,
    output logic [KELIME_W*KELIME_SAYISI-1:0]   obek
);

    always_ff @(posedge clk) begin
        if (rst) begin
            obek <= '0;
        end else begin
            for (int i = 0; i < KELIME_SAYISI; i++) begin
                if (yaz && (indeks == INDEKS_W'(i))) begin
                    obek[KELIME_W*i +: KELIME_W] <= kelime;
                end
            end
        end
    end

endmodule

// File: rtl/buyruk_obek_getirici.sv
// Instruction-cache miss responder. On a miss it reads the 16-byte line
// containing the missed address from main memory one word at a time (one
// outstanding beat), assembles the words and hands the block to the cache
// with a one-cycle valid pulse.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   istek_i, istek_adres_i - miss request (level) and missed address
//   iptal_i                - abort the current fetch
//   mesgul_o               - fetch in progress
//   obek_o, obek_adres_o   - delivered block and its line-aligned address
//   obek_gecerli_o         - one-cycle pulse when the block is delivered
//   hata_o                 - one-cycle pulse when a beat times out
//   bellek_istek_o/_adres_o/_hazir_i - memory request handshake
//   bellek_veri_i/_gecerli_i         - memory read data return
module buyruk_obek_getirici
    import buyruk_obek_getirici_pkg::*;
#(
    parameter int KELIME_SAYISI  = VARSAYILAN_KELIME_SAYISI,
    parameter int ZAMAN_ASIMI    = VARSAYILAN_ZAMAN_ASIMI,
    parameter int SAYAC_GENISLIK = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               istek_i,
    input  logic [31:0]                        istek_adres_i,
    input  logic                               iptal_i,
    output logic                               mesgul_o,
    output logic [KELIME_W*KELIME_SAYISI-1:0]  obek_o,
    output logic                               obek_gecerli_o,
    output logic [31:0]                        obek_adres_o,
    output logic                               hata_o,
    output logic                               bellek_istek_o,
    output logic [31:0]                        bellek_adres_o,
    input  logic                               bellek_hazir_i,
    input  logic [31:0]                        bellek_veri_i,
    input  logic                               bellek_veri_gecerli_i
);

    localparam int INDEKS_W = (KELIME_SAYISI > 1) ? $clog2(KELIME_SAYISI) : 1;
    localparam logic [INDEKS_W-1:0]       SON_INDEKS = INDEKS_W'(KELIME_SAYISI - 1);
    localparam logic [SAYAC_GENISLIK-1:0] ASIM_SON   = SAYAC_GENISLIK'(ZAMAN_ASIMI - 1);

    durum_t                    durum;
    durum_t                    sonraki;
    logic [INDEKS_W-1:0]       indeks;
    logic [SAYAC_GENISLIK-1:0] bekleme;
    logic                      iptal_bayrak;
    logic [31:0]               satir_adres;
    logic                      son_kelime;
    logic                      asim;
    logic                      yaz;

    assign son_kelime = (indeks == SON_INDEKS);
    // The counter holds the number of empty VERI cycles already waited, so
    // the ZAMAN_ASIMI-th empty cycle is the one that gives up.
    assign asim = (durum == VERI) && !bellek_veri_gecerli_i && (bekleme == ASIM_SON);
    // A beat drained after an abort is accepted from memory but not stored.
    assign yaz  = (durum == VERI) && bellek_veri_gecerli_i && !iptal_bayrak && !iptal_i;

    assign bellek_adres_o = satir_adres + 32'({indeks, 2'b00});
    assign obek_adres_o   = satir_adres;

    obek_birlestirici #(
        .KELIME_SAYISI(KELIME_SAYISI)
    ) u_birlestirici (
        .clk    (clk_i),
        .rst    (rst_i),
        .yaz    (yaz),
        .indeks (indeks),
        .kelime (bellek_veri_i),
        .obek   (obek_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum <= BOSTA;
        end else begin
            durum <= sonraki;
        end
    end

    always_comb begin
        sonraki = durum;
        case (durum)
            BOSTA: begin
                if (istek_i && !iptal_i) sonraki = ISTEK;
            end
            ISTEK: begin
                // A completed handshake wins over a same-cycle abort: the beat
                // is then outstanding and must be drained in VERI.
                if (bellek_hazir_i)  sonraki = VERI;
                else if (iptal_i)    sonraki = BOSTA;
            end
            VERI: begin
                if (bellek_veri_gecerli_i) begin
                    if (iptal_bayrak || iptal_i) sonraki = BOSTA;
                    else if (son_kelime)         sonraki = TESLIM;
                    else                         sonraki = ISTEK;
                end else if (asim) begin
                    sonraki = BOSTA;
                end
            end
            TESLIM:  sonraki = BOSTA;
            default: sonraki = BOSTA;
        endcase
    end

    always_comb begin
        mesgul_o       = (durum != BOSTA);
        bellek_istek_o = (durum == ISTEK);
        obek_gecerli_o = (durum == TESLIM);
        hata_o         = asim;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            indeks       <= '0;
            bekleme      <= '0;
            iptal_bayrak <= 1'b0;
            satir_adres  <= '0;
        end else begin
            case (durum)
                BOSTA: begin
                    iptal_bayrak <= 1'b0;
                    if (istek_i && !iptal_i) begin
                        satir_adres <= satir_hizala(istek_adres_i);
                        indeks      <= '0;
                    end
                end
                ISTEK: begin
                    if (bellek_hazir_i) begin
                        bekleme <= '0;
                        if (iptal_i) iptal_bayrak <= 1'b1;
                    end
                end
                VERI: begin
                    if (iptal_i) iptal_bayrak <= 1'b1;
                    if (bellek_veri_gecerli_i) begin
                        if (!son_kelime) indeks <= indeks + 1'b1;
                    end else begin
                        bekleme <= bekleme + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buyruk_obek_getirici.sv
// Testbench for buyruk_obek_getirici: a memory responder with adjustable
// ready/latency behaviour, an event monitor, and one directed/randomized
// sequence checking each delivered line against a line-level model.
module tb_buyruk_obek_getirici;

    localparam int KS = 4;
    localparam int ZA = 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              istek_i = 1'b0;
    logic [31:0]       istek_adres_i = '0;
    logic              iptal_i = 1'b0;
    logic              mesgul_o;
    logic [32*KS-1:0]  obek_o;
    logic              obek_gecerli_o;
    logic [31:0]       obek_adres_o;
    logic              hata_o;
    logic              bellek_istek_o;
    logic [31:0]       bellek_adres_o;
    logic              bellek_hazir_i = 1'b0;
    logic [31:0]       bellek_veri_i = '0;
    logic              bellek_veri_gecerli_i = 1'b0;

    always #5 clk = ~clk;

    buyruk_obek_getirici #(
        .KELIME_SAYISI (KS),
        .ZAMAN_ASIMI   (ZA),
        .SAYAC_GENISLIK(8)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .istek_i              (istek_i),
        .istek_adres_i        (istek_adres_i),
        .iptal_i              (iptal_i),
        .mesgul_o             (mesgul_o),
        .obek_o               (obek_o),
        .obek_gecerli_o       (obek_gecerli_o),
        .obek_adres_o         (obek_adres_o),
        .hata_o               (hata_o),
        .bellek_istek_o       (bellek_istek_o),
        .bellek_adres_o       (bellek_adres_o),
        .bellek_hazir_i       (bellek_hazir_i),
        .bellek_veri_i        (bellek_veri_i),
        .bellek_veri_gecerli_i(bellek_veri_gecerli_i)
    );

    int toplam = 0;
    int bad    = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory contents: every word is a fixed function of its byte address.
    function automatic logic [31:0] mem_w(input logic [31:0] a, input logic [31:0] t);
        return a ^ 32'hA5A5_A5A5 ^ t;
    endfunction

    // Memory responder knobs (written only by the main sequence).
    int          hazir_yuzde  = 100;
    int          bp_beat      = -1;
    int          bp_cycles    = 0;
    int          veri_gecikme = 1;
    bit          veri_yok     = 1'b0;
    logic [31:0] tuz          = '0;

    bit          bekleyen   = 1'b0;
    int          geri_sayim = 0;
    int          bekleme    = 0;
    logic [31:0] bek_adres  = '0;

    initial forever begin
        @(negedge clk);
        bellek_veri_gecerli_i = 1'b0;
        bellek_veri_i         = $urandom;
        if (bekleyen) begin
            if (geri_sayim == 0) begin
                bellek_veri_gecerli_i = 1'b1;
                bellek_veri_i         = mem_w(bek_adres, tuz);
                bekleyen              = 1'b0;
            end else begin
                geri_sayim--;
            end
        end
        if (bellek_istek_o) begin
            if (bp_beat >= 0 && int'(bellek_adres_o[3:2]) == bp_beat && bekleme < bp_cycles)
                bellek_hazir_i = 1'b0;
            else
                bellek_hazir_i = ($urandom_range(0, 99) < hazir_yuzde);
            if (bellek_hazir_i) begin
                bekleme = 0;
                if (!veri_yok) begin
                    bekleyen   = 1'b1;
                    geri_sayim = veri_gecikme - 1;
                    bek_adres  = bellek_adres_o;
                end
            end else begin
                bekleme++;
            end
        end else begin
            bellek_hazir_i = 1'($urandom_range(0, 1));
            bekleme        = 0;
        end
    end

    // Event monitor: accepted addresses, pulses, and request-hold violations.
    logic [31:0]  kabul_q[$];
    int           kabul_cyc  = 0;
    int           gec_say    = 0;
    int           gec_cyc    = 0;
    logic [127:0] gec_obek   = '0;
    logic [31:0]  gec_adres  = '0;
    int           hata_say   = 0;
    int           hata_cyc   = 0;
    int           ihlal      = 0;
    bit           onceki_bek = 1'b0;
    bit           onceki_rst = 1'b0;
    logic [31:0]  onceki_adr = '0;

    initial forever begin
        @(negedge clk);
        #1;
        if (bellek_istek_o && bellek_hazir_i) begin
            kabul_q.push_back(bellek_adres_o);
            kabul_cyc = cyc;
        end
        if (obek_gecerli_o) begin
            gec_say++;
            gec_cyc   = cyc;
            gec_obek  = obek_o;
            gec_adres = obek_adres_o;
        end
        if (hata_o) begin
            hata_say++;
            hata_cyc = cyc;
        end
        if (onceki_bek && !onceki_rst && !(bellek_istek_o && bellek_adres_o == onceki_adr))
            ihlal++;
        onceki_bek = bellek_istek_o && !bellek_hazir_i;
        onceki_adr = bellek_adres_o;
        onceki_rst = rst_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic kontrol(input string ad, input logic [127:0] gozlenen, input logic [127:0] beklenen);
        toplam++;
        assert (gozlenen === beklenen) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", ad, gozlenen, beklenen);
        end
    endtask

    task automatic istek_ver(input logic [31:0] a, output int c0);
        @(negedge clk);
        istek_i       = 1'b1;
        istek_adres_i = a;
        c0            = cyc;
        @(negedge clk);
        istek_i       = 1'b0;
        istek_adres_i = $urandom;
    endtask

    task automatic bosta_bekle(input string ad, input int sinir);
        for (int i = 0; i < sinir; i++) begin
            @(negedge clk);
            #2;
            if (!mesgul_o) break;
        end
        kontrol({ad, "_idle"}, 128'(mesgul_o), 128'(0));
    endtask

    task automatic kabul_bekle(input int bas, input int n, input int sinir);
        #2;
        for (int i = 0; i < sinir; i++) begin
            if (kabul_q.size() - bas >= n) break;
            @(negedge clk);
            #2;
        end
        kontrol("accept_wait", 128'(kabul_q.size() - bas >= n), 128'(1));
    endtask

    // Line-level model: the delivered block is the KS words of the aligned
    // 16-byte line, lowest address in the lowest slot, fetched in order.
    task automatic dogrula(input string ad, input int bas, input int g0,
                           input logic [31:0] a, input logic [31:0] t);
        logic [31:0]  satir;
        logic [127:0] blk;
        satir = a & 32'hFFFF_FFF0;
        kontrol({ad, "_nbeats"}, 128'(kabul_q.size() - bas), 128'(KS));
        for (int i = 0; i < KS; i++) begin
            blk[32*i +: 32] = mem_w(satir + 32'(4*i), t);
            kontrol({ad, "_addr"}, 128'((bas + i < kabul_q.size()) ? kabul_q[bas+i] : 32'hx),
                    128'(satir + 32'(4*i)));
        end
        kontrol({ad, "_npulse"}, 128'(gec_say - g0), 128'(1));
        kontrol({ad, "_block"}, gec_obek, blk);
        kontrol({ad, "_baddr"}, 128'(gec_adres), 128'(satir));
        kontrol({ad, "_hold_block"}, obek_o, blk);
        kontrol({ad, "_hold_baddr"}, 128'(obek_adres_o), 128'(satir));
    endtask

    initial begin
        int          c0, bas, g0, h0;
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #2;
        kontrol("rst_gecerli", 128'(obek_gecerli_o), 128'(0));
        kontrol("rst_hata",    128'(hata_o),         128'(0));
        kontrol("rst_bistek",  128'(bellek_istek_o), 128'(0));
        kontrol("rst_mesgul",  128'(mesgul_o),       128'(0));
        kontrol("rst_obek",    obek_o,               128'(0));
        kontrol("rst_oadres",  128'(obek_adres_o),   128'(0));
        kontrol("rst_badres",  128'(bellek_adres_o), 128'(0));

        // Basic zero-wait fill
        tuz = '0;
        bas = kabul_q.size(); g0 = gec_say;
        istek_ver(32'h0000_1234, c0);
        bosta_bekle("basic", 40);
        dogrula("basic", bas, g0, 32'h0000_1234, 32'h0);
        kontrol("basic_latency", 128'(gec_cyc - c0), 128'(9));
        kontrol("basic_word0", 128'(gec_obek[31:0]), 128'(32'hA5A5_B795));

        // Back-pressure on beat 2
        tuz = $urandom; bp_beat = 2; bp_cycles = 3;
        bas = kabul_q.size(); g0 = gec_say;
        istek_ver(32'h0000_5678, c0);
        bosta_bekle("bp", 60);
        dogrula("bp", bas, g0, 32'h0000_5678, tuz);
        kontrol("bp_latency", 128'(gec_cyc - c0), 128'(12));
        kontrol("bp_hold", 128'(ihlal), 128'(0));
        bp_beat = -1;

        // Randomized fetches
        for (int n = 0; n < 12; n++) begin
            tuz          = $urandom;
            hazir_yuzde  = $urandom_range(30, 100);
            veri_gecikme = $urandom_range(1, 4);
            a            = $urandom;
            bas = kabul_q.size(); g0 = gec_say;
            istek_ver(a, c0);
            bosta_bekle("rand", 300);
            dogrula("rand", bas, g0, a, tuz);
        end
        kontrol("rand_hold", 128'(ihlal), 128'(0));
        hazir_yuzde = 100;

        // Data on the last allowed cycle is still accepted
        tuz = $urandom; veri_gecikme = ZA;
        bas = kabul_q.size(); g0 = gec_say; h0 = hata_say;
        istek_ver(32'h0001_0000, c0);
        bosta_bekle("slow", 100);
        dogrula("slow", bas, g0, 32'h0001_0000, tuz);
        kontrol("slow_nohata", 128'(hata_say - h0), 128'(0));
        veri_gecikme = 1;

        // Timeout: data never returns
        veri_yok = 1'b1;
        bas = kabul_q.size(); g0 = gec_say; h0 = hata_say;
        istek_ver(32'h0000_0300, c0);
        bosta_bekle("tmo", 40);
        kontrol("tmo_nhata",  128'(hata_say - h0),          128'(1));
        kontrol("tmo_when",   128'(hata_cyc - kabul_cyc),   128'(ZA));
        kontrol("tmo_npulse", 128'(gec_say - g0),           128'(0));
        kontrol("tmo_nbeats", 128'(kabul_q.size() - bas),   128'(1));
        veri_yok = 1'b0;
        repeat (2) @(negedge clk);

        // Flush while beat 1 is outstanding, data two cycles later
        tuz = $urandom; veri_gecikme = 3;
        bas = kabul_q.size(); g0 = gec_say; h0 = hata_say;
        istek_ver(32'h0000_0080, c0);
        kabul_bekle(bas, 2, 50);
        @(negedge clk); iptal_i = 1'b1;
        @(negedge clk); iptal_i = 1'b0;
        bosta_bekle("flush", 40);
        kontrol("flush_npulse", 128'(gec_say - g0),         128'(0));
        kontrol("flush_nbeats", 128'(kabul_q.size() - bas), 128'(2));
        kontrol("flush_nhata",  128'(hata_say - h0),        128'(0));
        repeat (3) @(negedge clk);
        veri_gecikme = 1; tuz = $urandom;
        bas = kabul_q.size(); g0 = gec_say;
        istek_ver(32'h0000_0040, c0);
        bosta_bekle("after_flush", 40);
        dogrula("after_flush", bas, g0, 32'h0000_0040, tuz);

        // Reset in the middle of beat 2
        veri_gecikme = 3;
        bas = kabul_q.size(); g0 = gec_say;
        istek_ver(32'h0000_2468, c0);
        kabul_bekle(bas, 3, 60);
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        #2;
        kontrol("mrst_gecerli", 128'(obek_gecerli_o), 128'(0));
        kontrol("mrst_hata",    128'(hata_o),         128'(0));
        kontrol("mrst_bistek",  128'(bellek_istek_o), 128'(0));
        kontrol("mrst_mesgul",  128'(mesgul_o),       128'(0));
        kontrol("mrst_obek",    obek_o,               128'(0));
        kontrol("mrst_oadres",  128'(obek_adres_o),   128'(0));
        kontrol("mrst_badres",  128'(bellek_adres_o), 128'(0));
        repeat (6) @(negedge clk);
        #2;
        kontrol("mrst_late_obek", obek_o,                 128'(0));
        kontrol("mrst_npulse",    128'(gec_say - g0),     128'(0));
        kontrol("mrst_idle",      128'(mesgul_o),         128'(0));
        veri_gecikme = 1;

        // Top-of-memory line
        tuz = $urandom;
        bas = kabul_q.size(); g0 = gec_say;
        istek_ver(32'hFFFF_FFF7, c0);
        bosta_bekle("top", 40);
        dogrula("top", bas, g0, 32'hFFFF_FFF7, tuz);
        kontrol("top_latency", 128'(gec_cyc - c0), 128'(9));

        $display("test done: total=%0d bad=%0d", toplam, bad);
        $finish;
    end

endmodule
